// File: rtl/prog_frq_div.sv
// prog_frq_div: runtime-loadable clock-enable divider with pulse and square outputs
module prog_frq_div #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode,
    output logic             out,
    output logic             tc,
    output logic             pend,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] d, s, d_n, s_n, cnt_n;
    logic             pend_n, bnd, ld_ok, sq;

    assign bnd   = cnt == d - WIDTH'(1);
    assign ld_ok = ld && (div_in != '0);
    assign tc    = en && bnd && !rst;
    assign sq    = ({1'b0, cnt} < (({1'b0, d} + (WIDTH+1)'(1)) >> 1)) && !rst;
    assign out   = mode ? sq : tc;

    // Next state: divisor swaps only at a period boundary, or immediately while halted
    always_comb begin
        d_n    = d;
        s_n    = s;
        pend_n = pend;
        cnt_n  = cnt;
        if (en) begin
            cnt_n = bnd ? '0 : cnt + WIDTH'(1);
            if (bnd) begin
                if (ld_ok) begin
                    d_n    = div_in;
                    pend_n = 1'b0;
                end else if (pend) begin
                    d_n    = s;
                    pend_n = 1'b0;
                end
            end else if (ld_ok) begin
                s_n    = div_in;
                pend_n = 1'b1;
            end
        end else if (ld_ok) begin
            d_n    = div_in;
            s_n    = div_in;
            pend_n = 1'b0;
            cnt_n  = '0;
        end else if (pend) begin
            d_n    = s;
            pend_n = 1'b0;
            cnt_n  = '0;
        end
    end

    // State registers with immediate reset to the default divisor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d    <= WIDTH'(DEFAULT_DIV);
            s    <= WIDTH'(DEFAULT_DIV);
            pend <= 1'b0;
            cnt  <= '0;
        end else begin
            d    <= d_n;
            s    <= s_n;
            pend <= pend_n;
            cnt  <= cnt_n;
        end
    end
endmodule
